diila_seq: RTL and testbench
============================

// Module: diila_seq
// PURPOSE
//  Wishbone-master sequencer for the diila trace logger. On arm_i it programs post-trigger count, skip count and trigger word (the trigger write arms).
//  On dump_i it reads the full trace memory, trig band then data bands, and emits it as a 32-bit valid/ready word stream.
//  Sits between a host command/stream port (UART/JTAG bridge) and the diila WB slave; sole master of that slave.
// PARAMETERS
//  DATA_WIDTH  96  diila data width; multiple of 32; DATA_WORDS=DATA_WIDTH/32, bands=DATA_WORDS+1
// PORTS
//  wb_clk_i      in   1     clock
//  wb_rst_ni     in   1     asynchronous reset, active low
//  arm_i         in   1     pulse: program + arm diila
//  dump_i        in   1     pulse: read out trace memory
//  cfg_trig_i    in   32    trigger match word (sampled on accepted arm_i)
//  cfg_post_i    in   10    post-trigger sample count (sampled on accepted arm_i)
//  cfg_skip_i    in   32    trigger skip count (sampled on accepted arm_i)
//  busy_o        out  1     FSM not IDLE
//  err_o         out  1     sticky: WB error seen; cleared on next accepted arm_i/dump_i
//  m_adr_o       out  22    WB address [23:2]
//  m_dat_o       out  32    WB write data
//  m_sel_o       out  4     byte selects, constant 4'hf
//  m_we_o        out  1     WB write enable
//  m_cyc_o       out  1     WB cycle
//  m_stb_o       out  1     WB strobe
//  m_dat_i       in   32    WB read data
//  m_ack_i       in   1     WB acknowledge
//  m_err_i       in   1     WB error
//  st_data_o     out  32    stream word
//  st_valid_o    out  1     stream valid
//  st_last_o     out  1     final word of dump
//  st_ready_i    in   1     stream ready
// BEHAVIOUR
//  Reset: all outputs 0 (m_sel_o 0 during reset, 4'hf after); FSM IDLE; counters 0. Async assert drops cyc/stb/valid immediately, mid-transfer too.
//  FSM: IDLE, WR_POST, WR_SKIP, WR_TRIG, RD_REQ, PUSH.
//  IDLE: arm_i -> latch cfg, WR_POST. dump_i -> clear band/idx, RD_REQ. Both same cycle: arm wins, dump dropped.
//   arm_i/dump_i outside IDLE ignored.
//  Writes (m_we_o=1): WR_POST adr 1 dat {22'b0,post}; WR_SKIP adr 2 dat skip; WR_TRIG adr 0 dat trig -> IDLE.
//  Each transfer: cyc/stb/adr/dat/we asserted on state entry, held until m_ack_i or m_err_i; cyc/stb low the following cycle.
//   One transfer in flight; >=1 idle cycle between transfers (diila acks every other cycle).
//  Reads: RD_REQ adr = {band[11:0], idx[9:0]}, we=0. On ack capture m_dat_i into st_data_o, st_valid_o=1, PUSH.
//  PUSH: hold data/valid/last stable until st_ready_i; on handshake idx++. idx wraps 1023->0 with band++.
//   After band=DATA_WORDS, idx=1023 -> IDLE; else RD_REQ.
//  st_last_o=1 only with word band=DATA_WORDS, idx=1023; total words = 1024*(DATA_WORDS+1).
//  Next read not issued until current word accepted (1-word buffer); st_valid_o never drops without ready.
//  m_err_i in any transfer: err_o<=1, cyc/stb drop, FSM -> IDLE, no stream word for that read.
//  busy_o combinational from state; 1 from cycle after accepted command until cycle after final handshake/ack.
//  Arm latency: accepted arm_i -> first stb next cycle; 3 writes done in 6+ cycles against diila.
// TESTING
//  arm_i cfg trig=0xA5, post=16, skip=2 -> writes (adr,dat) (1,0x10),(2,2),(0,0xA5) in order, busy 1->0.
//  dump_i, DATA_WIDTH=96, ready=1 -> 4096 words, adr 0x000..0xFFF in order, last only on adr 0xFFF.
//  dump with ready low 50 cycles at word 7 -> data/valid frozen, no new stb until handshake.
//  arm_i+dump_i same cycle -> only write sequence, no reads; dump_i while busy ignored.
//  m_err_i on 2nd write -> err_o=1, third write absent, IDLE; next arm_i clears err_o.
//  wb_rst_ni low mid-read -> cyc/stb/valid 0 same cycle; after release idle until new command.

Source files
------------

// File: rtl/diila_seq.sv
// ---------------------------------------------------------------------------
// diila_seq -- Wishbone-master sequencer for the diila trace logger.
//
// Purpose:
//   arm_i  : programs the post-trigger count (adr 1) and the skip count
//            (adr 2), then the trigger word (adr 0). Writing the trigger
//            word arms the logger.
//   dump_i : reads the whole trace memory. The trigger band is read first,
//            then the data bands. Each word is sent out on a 32-bit
//            valid/ready stream, and st_last_o marks the final word.
//   This block is the only master of the diila WB slave. Only one transfer
//   is in flight at a time, and there is at least one idle cycle between
//   transfers.
//
// Ports:
//   wb_clk_i, wb_rst_ni      clock, asynchronous active-low reset
//   arm_i, dump_i            command pulses, accepted only while idle
//   cfg_trig_i/post_i/skip_i configuration, sampled on an accepted arm_i
//   busy_o                   sequencer not idle
//   err_o                    sticky WB error; cleared by the next command
//   m_*                      Wishbone master (word address = byte adr[23:2])
//   st_data_o/valid_o/last_o stream output; st_ready_i is the back-pressure
// ---------------------------------------------------------------------------
module diila_seq #(
  parameter int DATA_WIDTH = 96
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_ni,
  input  logic        arm_i,
  input  logic        dump_i,
  input  logic [31:0] cfg_trig_i,
  input  logic [9:0]  cfg_post_i,
  input  logic [31:0] cfg_skip_i,
  output logic        busy_o,
  output logic        err_o,
  output logic [21:0] m_adr_o,
  output logic [31:0] m_dat_o,
  output logic [3:0]  m_sel_o,
  output logic        m_we_o,
  output logic        m_cyc_o,
  output logic        m_stb_o,
  input  logic [31:0] m_dat_i,
  input  logic        m_ack_i,
  input  logic        m_err_i,
  output logic [31:0] st_data_o,
  output logic        st_valid_o,
  output logic        st_last_o,
  input  logic        st_ready_i
);

  // Band 0 is the trigger band. Bands 1..DATA_WORDS hold the data words.
  localparam int          DATA_WORDS = DATA_WIDTH / 32;
  localparam logic [11:0] LAST_BAND  = 12'(DATA_WORDS);
  localparam logic [9:0]  LAST_IDX   = 10'h3ff;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WR_POST,
    S_WR_SKIP,
    S_WR_TRIG,
    S_RD_REQ,
    S_PUSH
  } state_t;

  state_t      state_q;

  // Configuration latched on an accepted arm_i.
  logic [9:0]  post_q;
  logic [31:0] skip_q;
  logic [31:0] trig_q;

  // Read cursor. The address sent on the bus is {band, idx}.
  logic [11:0] band_q;
  logic [9:0]  idx_q;
  logic [11:0] band_d;
  logic [9:0]  idx_d;
  logic        last_word;

  // Registered bus and stream outputs.
  logic [21:0] adr_q;
  logic [31:0] dat_q;
  logic [3:0]  sel_q;
  logic        we_q;
  logic        cyc_q;
  logic        stb_q;
  logic        err_q;
  logic [31:0] st_data_q;
  logic        st_valid_q;
  logic        st_last_q;

  // Address and data of the write that belongs to the current write state.
  logic [21:0] wr_adr;
  logic [31:0] wr_dat;

  always_comb begin
    idx_d     = idx_q + 10'd1;
    band_d    = (idx_q == LAST_IDX) ? band_q + 12'd1 : band_q;
    last_word = (band_q == LAST_BAND) && (idx_q == LAST_IDX);
  end

  always_comb begin
    wr_adr = 22'd1;
    wr_dat = {22'b0, post_q};
    case (state_q)
      S_WR_SKIP: begin
        wr_adr = 22'd2;
        wr_dat = skip_q;
      end
      S_WR_TRIG: begin
        wr_adr = 22'd0;
        wr_dat = trig_q;
      end
      default: ;
    endcase
  end

  // A transfer stays on the bus until it is acked or errored. On completion,
  // cyc/stb are cleared and the FSM moves to the next state with stb low.
  // That state raises stb one cycle later, which gives the idle gap between
  // transfers. The first transfer of a command is issued directly from
  // IDLE, so stb rises in the cycle after the command is accepted.
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      state_q    <= S_IDLE;
      post_q     <= '0;
      skip_q     <= '0;
      trig_q     <= '0;
      band_q     <= '0;
      idx_q      <= '0;
      adr_q      <= '0;
      dat_q      <= '0;
      sel_q      <= '0;
      we_q       <= 1'b0;
      cyc_q      <= 1'b0;
      stb_q      <= 1'b0;
      err_q      <= 1'b0;
      st_data_q  <= '0;
      st_valid_q <= 1'b0;
      st_last_q  <= 1'b0;
    end else begin
      sel_q <= 4'hf;
      case (state_q)
        S_IDLE: begin
          // arm_i has priority. A simultaneous dump_i is dropped.
          if (arm_i) begin
            err_q   <= 1'b0;
            post_q  <= cfg_post_i;
            skip_q  <= cfg_skip_i;
            trig_q  <= cfg_trig_i;
            cyc_q   <= 1'b1;
            stb_q   <= 1'b1;
            we_q    <= 1'b1;
            adr_q   <= 22'd1;
            dat_q   <= {22'b0, cfg_post_i};
            state_q <= S_WR_POST;
          end else if (dump_i) begin
            err_q   <= 1'b0;
            band_q  <= '0;
            idx_q   <= '0;
            cyc_q   <= 1'b1;
            stb_q   <= 1'b1;
            we_q    <= 1'b0;
            adr_q   <= '0;
            state_q <= S_RD_REQ;
          end
        end

        S_WR_POST, S_WR_SKIP, S_WR_TRIG: begin
          if (!stb_q) begin
            cyc_q <= 1'b1;
            stb_q <= 1'b1;
            we_q  <= 1'b1;
            adr_q <= wr_adr;
            dat_q <= wr_dat;
          end else if (m_err_i) begin
            cyc_q   <= 1'b0;
            stb_q   <= 1'b0;
            we_q    <= 1'b0;
            err_q   <= 1'b1;
            state_q <= S_IDLE;
          end else if (m_ack_i) begin
            cyc_q <= 1'b0;
            stb_q <= 1'b0;
            we_q  <= 1'b0;
            case (state_q)
              S_WR_POST: state_q <= S_WR_SKIP;
              S_WR_SKIP: state_q <= S_WR_TRIG;
              default:   state_q <= S_IDLE;
            endcase
          end
        end

        S_RD_REQ: begin
          if (!stb_q) begin
            cyc_q <= 1'b1;
            stb_q <= 1'b1;
            we_q  <= 1'b0;
            adr_q <= {band_q, idx_q};
          end else if (m_err_i) begin
            // An errored read produces no stream word.
            cyc_q   <= 1'b0;
            stb_q   <= 1'b0;
            err_q   <= 1'b1;
            state_q <= S_IDLE;
          end else if (m_ack_i) begin
            cyc_q      <= 1'b0;
            stb_q      <= 1'b0;
            st_data_q  <= m_dat_i;
            st_valid_q <= 1'b1;
            st_last_q  <= last_word;
            state_q    <= S_PUSH;
          end
        end

        S_PUSH: begin
          // Single-word buffer: the next read waits until this word has been
          // accepted.
          if (st_ready_i) begin
            st_valid_q <= 1'b0;
            st_last_q  <= 1'b0;
            idx_q      <= idx_d;
            band_q     <= band_d;
            state_q    <= last_word ? S_IDLE : S_RD_REQ;
          end
        end

        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign busy_o     = (state_q != S_IDLE);
  assign err_o      = err_q;
  assign m_adr_o    = adr_q;
  assign m_dat_o    = dat_q;
  assign m_sel_o    = sel_q;
  assign m_we_o     = we_q;
  assign m_cyc_o    = cyc_q;
  assign m_stb_o    = stb_q;
  assign st_data_o  = st_data_q;
  assign st_valid_o = st_valid_q;
  assign st_last_o  = st_last_q;

endmodule

// File: tb/tb_diila_seq.sv
// ---------------------------------------------------------------------------
// tb_diila_seq -- directed bench for diila_seq.
//
// A small WB slave answers each transfer with a one-cycle ack (or err) in
// the cycle after stb is seen. Read data is {10'h155, adr}. Completed bus
// transfers and stream handshakes are logged into queues. The scenario
// tasks compare those queues and the DUT outputs against hand-derived
// values.
// ---------------------------------------------------------------------------
module tb_diila_seq;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        arm = 1'b0;
  logic        dump = 1'b0;
  logic [31:0] cfg_trig = '0;
  logic [9:0]  cfg_post = '0;
  logic [31:0] cfg_skip = '0;
  logic        busy, err;
  logic [21:0] m_adr;
  logic [31:0] m_dat;
  logic [3:0]  m_sel;
  logic        m_we, m_cyc, m_stb;
  logic [31:0] s_dat = '0;
  logic        s_ack = 1'b0;
  logic        s_err = 1'b0;
  logic [31:0] st_data;
  logic        st_valid, st_last;
  logic        st_ready = 1'b1;

  always #5 clk = ~clk;

  diila_seq #(.DATA_WIDTH(96)) dut (
    .wb_clk_i(clk), .wb_rst_ni(rst_n), .arm_i(arm), .dump_i(dump),
    .cfg_trig_i(cfg_trig), .cfg_post_i(cfg_post), .cfg_skip_i(cfg_skip),
    .busy_o(busy), .err_o(err),
    .m_adr_o(m_adr), .m_dat_o(m_dat), .m_sel_o(m_sel), .m_we_o(m_we),
    .m_cyc_o(m_cyc), .m_stb_o(m_stb), .m_dat_i(s_dat), .m_ack_i(s_ack),
    .m_err_i(s_err), .st_data_o(st_data), .st_valid_o(st_valid),
    .st_last_o(st_last), .st_ready_i(st_ready)
  );

  int total = 0;
  int bad = 0;

  // WB slave. err_on_write selects which write (counted from the start of
  // the run) is answered with an error.
  int wr_cnt = 0;
  int err_on_write = 0;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_ack <= 1'b0;
      s_err <= 1'b0;
    end else begin
      s_ack <= 1'b0;
      s_err <= 1'b0;
      if (m_cyc && m_stb && !s_ack && !s_err) begin
        if (m_we) begin
          wr_cnt <= wr_cnt + 1;
          if (wr_cnt + 1 == err_on_write) s_err <= 1'b1;
          else s_ack <= 1'b1;
        end else begin
          s_ack <= 1'b1;
          s_dat <= {10'h155, m_adr};
        end
      end
    end
  end

  // Monitor.
  logic [21:0] wq_adr[$];
  logic [31:0] wq_dat[$];
  logic        wq_we[$];
  logic        wq_err[$];
  logic [31:0] sq_dat[$];
  logic        sq_last[$];
  int hs_count = 0;
  int stb_cycles = 0;
  int gap_err = 0;
  logic ack_last = 1'b0;

  always @(posedge clk) begin
    if (m_stb) stb_cycles <= stb_cycles + 1;
    if (ack_last && m_stb) gap_err <= gap_err + 1;
    ack_last <= m_cyc && m_stb && (s_ack || s_err);
    if (m_cyc && m_stb && (s_ack || s_err)) begin
      wq_adr.push_back(m_adr);
      wq_dat.push_back(m_dat);
      wq_we.push_back(m_we);
      wq_err.push_back(s_err);
    end
    if (st_valid && st_ready) begin
      sq_dat.push_back(st_data);
      sq_last.push_back(st_last);
      hs_count <= hs_count + 1;
    end
  end

  task automatic clear_q();
    wq_adr.delete(); wq_dat.delete(); wq_we.delete(); wq_err.delete();
    sq_dat.delete(); sq_last.delete();
  endtask

  task automatic wait_idle(input int limit, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < limit; i++) begin
      @(negedge clk);
      if (!busy) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    total++;
    if ({busy, err, m_cyc, m_stb, m_we, st_valid, st_last} !== 7'b0) begin
      bad++;
      $display("FAIL reset_ctrl: got %b want 0000000", {busy, err, m_cyc, m_stb, m_we, st_valid, st_last});
    end
    total++;
    if (m_sel !== 4'h0) begin bad++; $display("FAIL reset_sel: got %h want 0", m_sel); end
    total++;
    if ({m_adr, m_dat, st_data} !== 86'b0) begin
      bad++; $display("FAIL reset_bus: adr %h dat %h sdat %h want 0", m_adr, m_dat, st_data);
    end
    rst_n = 1'b1;
    @(negedge clk);
    total++;
    if (m_sel !== 4'hf) begin bad++; $display("FAIL sel_after_reset: got %h want f", m_sel); end
    total++;
    if (busy !== 1'b0) begin bad++; $display("FAIL idle_after_reset: busy %b want 0", busy); end
  endtask

  task automatic test_arm(input logic [31:0] trig, input logic [9:0] post, input logic [31:0] skip);
    logic [21:0] ea[3];
    logic [31:0] ed[3];
    bit ok;
    int g0;
    clear_q();
    g0 = gap_err;
    ea[0] = 22'd1; ed[0] = {22'b0, post};
    ea[1] = 22'd2; ed[1] = skip;
    ea[2] = 22'd0; ed[2] = trig;
    cfg_trig = trig; cfg_post = post; cfg_skip = skip;
    @(negedge clk) arm = 1'b1;
    @(negedge clk) arm = 1'b0;
    total++;
    if ({busy, m_cyc, m_stb, m_we} !== 4'b1111 || m_adr !== 22'd1 || m_dat !== {22'b0, post}) begin
      bad++;
      $display("FAIL arm_first_stb: busy/cyc/stb/we %b adr %h dat %h want 1111 1 %h",
               {busy, m_cyc, m_stb, m_we}, m_adr, m_dat, {22'b0, post});
    end
    wait_idle(100, ok);
    total++;
    if (!ok) begin bad++; $display("FAIL arm_done: busy %b want 0 within 100 cycles", busy); end
    total++;
    if (wq_adr.size() != 3) begin bad++; $display("FAIL arm_count: got %0d want 3", wq_adr.size()); end
    for (int i = 0; i < 3 && i < wq_adr.size(); i++) begin
      total++;
      if (wq_adr[i] !== ea[i] || wq_dat[i] !== ed[i] || wq_we[i] !== 1'b1 || wq_err[i] !== 1'b0) begin
        bad++;
        $display("FAIL arm_write%0d: adr %h dat %h we %b err %b want adr %h dat %h we 1 err 0",
                 i, wq_adr[i], wq_dat[i], wq_we[i], wq_err[i], ea[i], ed[i]);
      end
    end
    total++;
    if (gap_err != g0 || err !== 1'b0) begin
      bad++; $display("FAIL arm_gap: gaps %0d err %b want 0 0", gap_err - g0, err);
    end
  endtask

  task automatic test_dump_stall();
    bit ok, stalled;
    int hs0, sc, frozen_bad, eread, estream, nlast, g0;
    logic [31:0] snap;
    clear_q();
    st_ready = 1'b1;
    hs0 = hs_count;
    g0 = gap_err;
    stalled = 1'b0;
    ok = 1'b0;
    @(negedge clk) dump = 1'b1;
    @(negedge clk) dump = 1'b0;
    total++;
    if ({busy, m_cyc, m_stb, m_we} !== 4'b1110 || m_adr !== 22'd0) begin
      bad++; $display("FAIL dump_first_stb: busy/cyc/stb/we %b adr %h want 1110 0", {busy, m_cyc, m_stb, m_we}, m_adr);
    end
    for (int i = 0; i < 30000; i++) begin
      @(negedge clk);
      if (!busy) begin
        ok = 1'b1;
        break;
      end
      if (!stalled && st_valid && (hs_count - hs0 == 7)) begin
        stalled = 1'b1;
        st_ready = 1'b0;
        snap = st_data;
        sc = stb_cycles;
        frozen_bad = 0;
        repeat (50) begin
          @(negedge clk);
          if (st_valid !== 1'b1 || st_data !== snap || busy !== 1'b1) frozen_bad++;
        end
        total++;
        if (frozen_bad != 0) begin bad++; $display("FAIL stall_frozen: %0d bad cycles want 0", frozen_bad); end
        total++;
        if (stb_cycles != sc) begin bad++; $display("FAIL stall_no_stb: %0d stb cycles want 0", stb_cycles - sc); end
        total++;
        if (snap !== {10'h155, 22'd7}) begin bad++; $display("FAIL stall_word: got %h want %h", snap, {10'h155, 22'd7}); end
        st_ready = 1'b1;
      end
    end
    total++;
    if (!ok || !stalled) begin bad++; $display("FAIL dump_done: done %b stalled %b want 1 1", ok, stalled); end
    total++;
    if (wq_adr.size() != 4096 || sq_dat.size() != 4096) begin
      bad++; $display("FAIL dump_count: reads %0d words %0d want 4096 4096", wq_adr.size(), sq_dat.size());
    end else begin
      eread = 0; estream = 0; nlast = 0;
      for (int i = 0; i < 4096; i++) begin
        if (wq_adr[i] !== 22'(i) || wq_we[i] !== 1'b0 || wq_err[i] !== 1'b0) eread++;
        if (sq_dat[i] !== {10'h155, 22'(i)} || sq_last[i] !== (i == 4095)) estream++;
        if (sq_last[i] === 1'b1) nlast++;
      end
      total++;
      if (eread != 0) begin bad++; $display("FAIL dump_read_order: %0d bad reads want 0", eread); end
      total++;
      if (estream != 0 || nlast != 1) begin
        bad++; $display("FAIL dump_stream: %0d bad words, %0d lasts want 0, 1", estream, nlast);
      end
    end
    total++;
    if (gap_err != g0 || err !== 1'b0) begin
      bad++; $display("FAIL dump_gap: gaps %0d err %b want 0 0", gap_err - g0, err);
    end
  endtask

  task automatic test_arm_dump_same();
    bit ok;
    clear_q();
    cfg_trig = 32'h1234_5678; cfg_post = 10'h3ff; cfg_skip = 32'hdead_beef;
    @(negedge clk) begin arm = 1'b1; dump = 1'b1; end
    @(negedge clk) begin arm = 1'b0; dump = 1'b0; end
    // Commands while busy must be ignored, and so must a change of config.
    @(negedge clk) dump = 1'b1;
    @(negedge clk) begin dump = 1'b0; arm = 1'b1; cfg_trig = 32'h0000_0bad; end
    @(negedge clk) arm = 1'b0;
    wait_idle(100, ok);
    repeat (8) @(negedge clk);
    total++;
    if (!ok || busy !== 1'b0) begin bad++; $display("FAIL both_idle: done %b busy %b want 1 0", ok, busy); end
    total++;
    if (wq_adr.size() != 3) begin
      bad++; $display("FAIL both_count: got %0d transfers want 3", wq_adr.size());
    end else begin
      total++;
      if (wq_we[0] !== 1'b1 || wq_we[1] !== 1'b1 || wq_we[2] !== 1'b1) begin
        bad++; $display("FAIL both_no_reads: we %b%b%b want 111", wq_we[0], wq_we[1], wq_we[2]);
      end
      total++;
      if (wq_dat[0] !== 32'h3ff || wq_dat[1] !== 32'hdead_beef || wq_adr[2] !== 22'd0 || wq_dat[2] !== 32'h1234_5678) begin
        bad++; $display("FAIL both_data: %h %h %h/%h want 3ff deadbeef 0/12345678", wq_dat[0], wq_dat[1], wq_adr[2], wq_dat[2]);
      end
    end
    total++;
    if (sq_dat.size() != 0) begin bad++; $display("FAIL both_stream: got %0d words want 0", sq_dat.size()); end
  endtask

  task automatic test_err();
    bit ok;
    clear_q();
    err_on_write = wr_cnt + 2;
    cfg_trig = 32'h77; cfg_post = 10'd5; cfg_skip = 32'd9;
    @(negedge clk) arm = 1'b1;
    @(negedge clk) arm = 1'b0;
    wait_idle(100, ok);
    repeat (6) @(negedge clk);
    total++;
    if (!ok || err !== 1'b1) begin bad++; $display("FAIL err_sticky: done %b err %b want 1 1", ok, err); end
    total++;
    if (wq_adr.size() != 2) begin
      bad++; $display("FAIL err_count: got %0d transfers want 2", wq_adr.size());
    end else begin
      total++;
      if (wq_err[0] !== 1'b0 || wq_err[1] !== 1'b1 || wq_adr[1] !== 22'd2) begin
        bad++; $display("FAIL err_second: err %b%b adr %h want 01 2", wq_err[0], wq_err[1], wq_adr[1]);
      end
    end
    err_on_write = 0;
    clear_q();
    @(negedge clk) arm = 1'b1;
    @(negedge clk) arm = 1'b0;
    total++;
    if (err !== 1'b0) begin bad++; $display("FAIL err_clear: got %b want 0", err); end
    wait_idle(100, ok);
    total++;
    if (!ok || wq_adr.size() != 3 || err !== 1'b0) begin
      bad++; $display("FAIL err_rearm: done %b transfers %0d err %b want 1 3 0", ok, wq_adr.size(), err);
    end
  endtask

  task automatic test_reset_mid();
    bit found;
    int hs0, sc;
    for (int k = 0; k < 2; k++) begin
      clear_q();
      st_ready = 1'b1;
      hs0 = hs_count;
      @(negedge clk) dump = 1'b1;
      @(negedge clk) dump = 1'b0;
      found = 1'b0;
      for (int i = 0; i < 200; i++) begin
        @(negedge clk);
        if ((hs_count - hs0 >= 3) && ((k == 0) ? m_stb : st_valid)) begin
          found = 1'b1;
          break;
        end
      end
      total++;
      if (!found) begin bad++; $display("FAIL rstmid_reach%0d: no mid-read point within 200 cycles", k); end
      #2 rst_n = 1'b0;
      #1;
      total++;
      if ({m_cyc, m_stb, st_valid, busy} !== 4'b0 || m_sel !== 4'h0) begin
        bad++; $display("FAIL rstmid_drop%0d: cyc/stb/valid/busy %b sel %h want 0000 0", k, {m_cyc, m_stb, st_valid, busy}, m_sel);
      end
      @(negedge clk) rst_n = 1'b1;
      sc = stb_cycles;
      repeat (10) @(negedge clk);
      total++;
      if (busy !== 1'b0 || st_valid !== 1'b0 || stb_cycles != sc) begin
        bad++; $display("FAIL rstmid_idle%0d: busy %b valid %b stb cycles %0d want 0 0 0", k, busy, st_valid, stb_cycles - sc);
      end
    end
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_arm(32'h0000_00a5, 10'd16, 32'd2);
    test_dump_stall();
    test_arm_dump_same();
    test_err();
    test_reset_mid();
    test_arm(32'hcafe_f00d, 10'h2aa, 32'h0001_0000);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
